// File: rtl/sensor_host_pkg.sv
// Shared definitions for the sensor host reader: FSM states, error codes
// and the UART bit period derived from the default clock and baud rate.
package sensor_host_pkg;

   localparam int DEF_CLK_FREQ = 10000;
   localparam int DEF_BAUD     = 1000;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SEND       = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_RECV       = 3'd3,
      ST_DONE       = 3'd4,
      ST_FAIL       = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_FRAME   = 2'd2
   } err_t;

   function automatic int calc_bit_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   localparam int BIT_DIV = calc_bit_div(DEF_CLK_FREQ, DEF_BAUD);

endpackage

// File: rtl/host_uart_rx.sv
// UART receive path: rx synchronizer, start-edge detection, mid-bit sampling
// of 8N1 frames. Only listens while arm is high; dropping arm aborts a frame.
module host_uart_rx
   import sensor_host_pkg::*;
#(
   parameter int BIT_DIV = sensor_host_pkg::BIT_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       rx,
   output logic       start_seen,
   output logic       glitch,
   output logic       byte_ready,
   output logic       frame_err,
   output logic [7:0] data
);

   localparam logic [15:0] HALF_M1 = 16'(BIT_DIV / 2 - 1);
   localparam logic [15:0] BIT_M1  = 16'(BIT_DIV - 1);

   logic        sync1_r;
   logic        sync2_r;
   logic        prev_r;
   logic        active_r;
   logic        start_ph_r;
   logic [15:0] div_cnt_r;
   logic [3:0]  bit_cnt_r;
   logic [7:0]  shift_r;

   // Synchronizer, edge detection and per-bit sampling sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r    <= 1'b1;
         sync2_r    <= 1'b1;
         prev_r     <= 1'b1;
         active_r   <= 1'b0;
         start_ph_r <= 1'b0;
         div_cnt_r  <= 16'd0;
         bit_cnt_r  <= 4'd0;
         shift_r    <= 8'd0;
         data       <= 8'd0;
         start_seen <= 1'b0;
         glitch     <= 1'b0;
         byte_ready <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1_r    <= rx;
         sync2_r    <= sync1_r;
         prev_r     <= sync2_r;
         start_seen <= 1'b0;
         glitch     <= 1'b0;
         byte_ready <= 1'b0;
         frame_err  <= 1'b0;
         if (!arm) begin
            active_r   <= 1'b0;
            start_ph_r <= 1'b0;
            div_cnt_r  <= 16'd0;
         end else if (!active_r) begin
            if (prev_r && !sync2_r) begin
               active_r   <= 1'b1;
               start_ph_r <= 1'b1;
               div_cnt_r  <= 16'd0;
               bit_cnt_r  <= 4'd0;
               start_seen <= 1'b1;
            end
         end else if (start_ph_r) begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (div_cnt_r == HALF_M1) begin
               div_cnt_r  <= 16'd0;
               start_ph_r <= 1'b0;
               if (sync2_r) begin
                  active_r <= 1'b0;
                  glitch   <= 1'b1;
               end
            end else begin
               div_cnt_r <= div_cnt_r + 16'd1;
            end
         end else begin
            if (div_cnt_r == BIT_M1) begin
               div_cnt_r <= 16'd0;
               if (bit_cnt_r == 4'd8) begin
                  active_r <= 1'b0;
                  if (sync2_r) begin
                     data       <= shift_r;
                     byte_ready <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  shift_r   <= {sync2_r, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 4'd1;
               end
            end else begin
               div_cnt_r <= div_cnt_r + 16'd1;
            end
         end
      end
   end

endmodule

// File: rtl/sensor_host_reader.sv
// Host side of a UART sensor link: sends one request byte, then assembles a
// 24-bit little-endian average from three reply bytes, with timeout/framing errors.
module sensor_host_reader
   import sensor_host_pkg::*;
#(
   parameter int         CLK_FREQ = 10000,
   parameter int         BAUD     = 1000,
   parameter logic [7:0] CMD_BYTE = 8'h52,
   parameter int         TIMEOUT  = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rx,
   output logic        tx,
   output logic        busy,
   output logic [23:0] value,
   output logic        valid,
   output logic [1:0]  err,
   output logic        err_pulse
);

   localparam int          BIT_DIV_P = calc_bit_div(CLK_FREQ, BAUD);
   localparam logic [15:0] BIT_M1    = 16'(BIT_DIV_P - 1);
   localparam logic [15:0] TO_M1     = 16'(TIMEOUT - 1);
   localparam logic [9:0]  FRAME     = {1'b1, CMD_BYTE, 1'b0};

   state_t      state_r;
   logic [15:0] div_cnt_r;
   logic [15:0] to_cnt_r;
   logic [3:0]  bit_idx_r;
   logic [8:0]  tx_shift_r;
   logic [1:0]  byte_idx_r;
   logic [15:0] staging_r;
   logic        arm_s;
   logic        start_seen_s;
   logic        glitch_s;
   logic        byte_ready_s;
   logic        frame_err_s;
   logic [7:0]  rx_byte_s;

   // The receiver only listens while a reply byte is expected.
   always_comb begin
      arm_s = (state_r == ST_WAIT_START) || (state_r == ST_RECV);
   end

   host_uart_rx #(.BIT_DIV(BIT_DIV_P)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .arm        (arm_s),
      .rx         (rx),
      .start_seen (start_seen_s),
      .glitch     (glitch_s),
      .byte_ready (byte_ready_s),
      .frame_err  (frame_err_s),
      .data       (rx_byte_s)
   );

   // Transaction sequencer with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         valid      <= 1'b0;
         err        <= ERR_NONE;
         err_pulse  <= 1'b0;
         value      <= 24'd0;
         div_cnt_r  <= 16'd0;
         to_cnt_r   <= 16'd0;
         bit_idx_r  <= 4'd0;
         tx_shift_r <= 9'd0;
         byte_idx_r <= 2'd0;
         staging_r  <= 16'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r    <= ST_SEND;
                  busy       <= 1'b1;
                  err        <= ERR_NONE;
                  tx         <= FRAME[0];
                  tx_shift_r <= FRAME[9:1];
                  div_cnt_r  <= 16'd0;
                  bit_idx_r  <= 4'd0;
               end
            end
            ST_SEND: begin
               if (div_cnt_r == BIT_M1) begin
                  div_cnt_r <= 16'd0;
                  if (bit_idx_r == 4'd9) begin
                     state_r    <= ST_WAIT_START;
                     tx         <= 1'b1;
                     byte_idx_r <= 2'd0;
                     to_cnt_r   <= 16'd0;
                  end else begin
                     bit_idx_r  <= bit_idx_r + 4'd1;
                     tx         <= tx_shift_r[0];
                     tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + 16'd1;
               end
            end
            ST_WAIT_START: begin
               if (start_seen_s) begin
                  state_r <= ST_RECV;
               end else if (to_cnt_r == TO_M1) begin
                  state_r   <= ST_FAIL;
                  err       <= ERR_TIMEOUT;
                  err_pulse <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  to_cnt_r <= to_cnt_r + 16'd1;
               end
            end
            ST_RECV: begin
               // A glitch resumes waiting with the timeout budget already spent.
               if (glitch_s) begin
                  state_r <= ST_WAIT_START;
               end else if (frame_err_s) begin
                  state_r   <= ST_FAIL;
                  err       <= ERR_FRAME;
                  err_pulse <= 1'b1;
                  busy      <= 1'b0;
               end else if (byte_ready_s) begin
                  if (byte_idx_r == 2'd2) begin
                     value   <= {rx_byte_s, staging_r};
                     valid   <= 1'b1;
                     busy    <= 1'b0;
                     state_r <= ST_DONE;
                  end else begin
                     if (byte_idx_r == 2'd0) begin
                        staging_r[7:0] <= rx_byte_s;
                     end else begin
                        staging_r[15:8] <= rx_byte_s;
                     end
                     byte_idx_r <= byte_idx_r + 2'd1;
                     to_cnt_r   <= 16'd0;
                     state_r    <= ST_WAIT_START;
                  end
               end
            end
            ST_DONE: begin
               valid   <= 1'b0;
               state_r <= ST_IDLE;
            end
            ST_FAIL: begin
               err_pulse <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_host_reader.sv
// Randomized scoreboard bench for sensor_host_reader: a sensor model drives rx,
// monitors decode tx frames and check every valid/err_pulse against expectations.
module tb_sensor_host_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rx;
   logic        tx;
   logic        busy;
   logic [23:0] value;
   logic        valid;
   logic [1:0]  err;
   logic        err_pulse;

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      logic [23:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  txq[$];
   logic [23:0] model_value = 24'd0;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          pulse_cyc = 0;

   sensor_host_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rx        (rx),
      .tx        (tx),
      .busy      (busy),
      .value     (value),
      .valid     (valid),
      .err       (err),
      .err_pulse (err_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result monitor: every completion pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (valid || err_pulse)) begin
         if (err_pulse) pulse_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: valid=%0b err_pulse=%0b value=%h", valid, err_pulse, value);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_is_err", 32'(err_pulse), 32'(e.is_err));
            chk("pulse_is_valid", 32'(valid), 32'(!e.is_err));
            chk("value", 32'(value), 32'(e.val));
            chk("err_code", 32'(err), 32'(e.code));
            chk("busy_at_end", 32'(busy), 32'd0);
         end
      end
   end

   // Command monitor: decode each 8N1 frame seen on tx at mid-bit.
   initial begin
      logic [7:0] b;
      logic       sb;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            repeat (5) @(negedge clk);
            chk("tx_start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (10) @(negedge clk);
               b[i] = tx;
            end
            repeat (10) @(negedge clk);
            sb = tx;
            chk("tx_stop_bit", 32'(sb), 32'd1);
            if (txq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx_frame: byte %h with none expected", b);
            end else begin
               chk("tx_cmd_byte", 32'(b), 32'(txq.pop_front()));
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_tx"}, 32'(tx), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_valid"}, 32'(valid), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
      chk({tag, "_value"}, 32'(value), 32'd0);
   endtask

   task automatic send_bits(input logic [7:0] b, input bit stopb, input int nb);
      logic [9:0] fr;
      fr = {stopb, b, 1'b0};
      for (int i = 0; i < nb; i++) begin
         rx = fr[i];
         repeat (10) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic wait_idle(input bit poke);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         start = poke && (valid || err_pulse);
         n++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      if (poke) chk("start_with_pulse_ignored", 32'(busy), 32'd0);
   endtask

   task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int nresp, input int bad_idx, input bit glitch,
                          input bit dbl, input int gap_bits, input bit poke);
      int         acc;
      int         delay;
      exp_t       e;
      logic [7:0] bs[3];
      bs[0] = b0;
      bs[1] = b1;
      bs[2] = b2;
      repeat (3) @(negedge clk);
      start = 1'b1;
      acc = cyc + 1;
      txq.push_back(8'h52);
      if (bad_idx >= 0) begin
         e = '{1'b1, 2'd2, model_value};
      end else if (nresp < 3) begin
         e = '{1'b1, 2'd1, model_value};
      end else begin
         model_value = {b2, b1, b0};
         e = '{1'b0, 2'd0, model_value};
      end
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("err_cleared_on_start", 32'(err), 32'd0);
      if (dbl) begin
         repeat (20) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (30) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      delay = int'($urandom_range(0, 60));
      while (cyc < acc + 100 + delay) @(negedge clk);
      if (glitch) begin
         rx = 1'b0;
         repeat (3) @(negedge clk);
         rx = 1'b1;
         repeat (20) @(negedge clk);
      end
      for (int k = 0; k < nresp; k++) begin
         if (k > 0) repeat (gap_bits * 10) @(negedge clk);
         send_bits(bs[k], k != bad_idx, 10);
         if (k == bad_idx) break;
      end
      wait_idle(poke);
      if (nresp == 0) chk("timeout_latency", 32'(pulse_cyc - acc), 32'd500);
   endtask

   initial begin
      int lows;
      rst   = 1'b1;
      start = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("post_release");

      run_txn(8'h34, 8'h12, 8'h00, 3, -1, 1'b0, 1'b0, 2, 1'b0);
      run_txn(8'h00, 8'h00, 8'h00, 0, -1, 1'b0, 1'b0, 0, 1'b0);
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 2, 1, 1'b0, 1'b0, 2, 1'b1);
      run_txn(8'hFF, 8'hFF, 8'hFF, 3, -1, 1'b1, 1'b0, 2, 1'b0);
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 3, -1, 1'b0, 1'b1, 1, 1'b1);
      for (int t = 0; t < 4; t++) begin
         run_txn(8'($urandom), 8'($urandom), 8'($urandom), 3, -1, 1'b0, 1'b0,
                 int'($urandom_range(0, 4)), t[0]);
      end

      // Reset in the middle of the second reply byte.
      repeat (3) @(negedge clk);
      start = 1'b1;
      txq.push_back(8'h52);
      @(negedge clk);
      start = 1'b0;
      repeat (120) @(negedge clk);
      send_bits(8'($urandom), 1'b1, 10);
      repeat (20) @(negedge clk);
      send_bits(8'($urandom), 1'b1, 5);
      rst = 1'b1;
      model_value = 24'd0;
      @(negedge clk);
      check_reset("mid_frame_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("tx_idle_after_reset", 32'(lows), 32'd0);
      chk("busy_after_reset", 32'(busy), 32'd0);
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 3, -1, 1'b0, 1'b0, 2, 1'b0);

      repeat (20) @(negedge clk);
      chk("results_drained", 32'(exp_q.size()), 32'd0);
      chk("tx_frames_drained", 32'(txq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_host_reader.md
SENSOR_HOST_READER -- requirements
Module: sensor_host_reader

Interface
REQ-001 Parameter CLK_FREQ, default 10000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 1000: UART bit rate; BIT_DIV = CLK_FREQ/BAUD = 10 clocks per bit.
REQ-003 Parameter CMD_BYTE, default 8'h52: request byte sent to the sensor.
REQ-004 Parameter TIMEOUT, default 400: idle clocks allowed before any expected start bit.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to read one 24-bit average.
REQ-008 rx  input  1  UART line from sensor tx; idle high.
REQ-009 tx  output  1  UART line to sensor rx; idle high.
REQ-010 busy  output  1  high from accepted start until done or error pulse.
REQ-011 value  output  24  last assembled average.
REQ-012 valid  output  1  one-cycle pulse when value updates.
REQ-013 err  output  2  error code, held until the next accepted start: 0 none, 1 timeout, 2 framing.
REQ-014 err_pulse  output  1  one-cycle pulse when err is set nonzero.

Function
REQ-015 FSM states: IDLE, SEND, WAIT_START, RECV, DONE, FAIL.
REQ-016 IDLE: start=1 -> SEND, busy=1, err cleared to 0; start is ignored in every other state.
REQ-017 SEND: tx drives 8N1 frame of CMD_BYTE, LSB first, each bit BIT_DIV clocks; tx goes low on the cycle after start is accepted.
REQ-018 SEND -> WAIT_START at end of stop bit; byte index cleared to 0.
REQ-019 rx passes a 2-flop synchronizer (reset value 1); only the synchronized signal is used.
REQ-020 WAIT_START: synchronized rx falling edge -> RECV; timeout counter reset on entry.
REQ-021 WAIT_START: TIMEOUT clocks without an edge -> FAIL with err=1.
REQ-022 RECV: sample start bit at BIT_DIV/2 clocks after edge; if high, treat as glitch and return to WAIT_START without resetting the timeout counter.
REQ-023 RECV: 8 data bits sampled at mid-bit (every BIT_DIV thereafter), LSB first.
REQ-024 RECV: stop bit sampled at mid-bit; 0 -> FAIL with err=2; 1 -> byte stored.
REQ-025 Byte 0 -> staging[7:0], byte 1 -> [15:8], byte 2 -> [23:16].
REQ-026 After byte 0 or 1, -> WAIT_START with timeout counter reset; after byte 2 -> DONE.
REQ-027 DONE (one cycle): value <= staging, valid=1, busy=0, -> IDLE.
REQ-028 FAIL (one cycle): err_pulse=1, busy=0, value unchanged, -> IDLE.
REQ-029 value never changes except in DONE; a partial read never modifies value.
REQ-030 start asserted in the same cycle as valid or err_pulse is ignored (FSM not yet in IDLE).
REQ-031 tx is high in every state except SEND.

Reset
REQ-032 rst=1 asynchronously forces: state IDLE, tx=1, busy=0, valid=0, err=0, err_pulse=0, value=0, all counters 0, synchronizer flops 1.
REQ-033 rst asserted mid-frame aborts the frame; after release, tx stays high and no pulse is emitted.

Structure
REQ-034 The state encoding and err codes live in shared package sensor_host_pkg, along with a constant for BIT_DIV derived from the parameters.
REQ-035 Serial bit timing and sampling live in one sub-module, host_uart_rx (synchronizer, mid-bit sampling, stop-bit check; outputs byte, byte_ready, frame_err); transmit and sequencing live in the parent.

Verification
REQ-036 start pulse; model sends 0x34,0x12,0x00 with 2 idle bits between bytes -> tx shows 0x52 frame (100 clocks), valid pulse, value=24'h001234, err=0.
REQ-037 start; model never responds -> err_pulse after 100+400 clocks, err=1, value retains prior 24'h001234.
REQ-038 start; second byte has stop bit 0 -> err=2, err_pulse once, no valid pulse, value unchanged.
REQ-039 3-clock low glitch on rx during WAIT_START, then valid bytes 0xFF,0xFF,0xFF -> value=24'hFFFFFF, no error.
REQ-040 rst asserted midway through the RECV of byte 1 -> all outputs at reset values; the next full transaction returns the correct value.
REQ-041 start repeated while busy -> ignored; exactly one command frame on tx.
